alu_arbiter: RTL and testbench

- Shares one combinational ALU (32-bit operands, 3-bit control, sum/eq outputs) between NUM_REQ requesters, e.g. PC-increment and execute stage.
- Round-robin grant with valid/ready request handshake; operands latched, ALU driven for one cycle, result registered and returned to the granted requester.
- Sits between pipeline-stage requesters and the shared ALU instance; the ALU itself stays outside this block.

---
 rtl/alu_arb_pkg.sv | 14 +
 rtl/alu_arbiter_rr_picker.sv | 28 ++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU arbiter.
package alu_arb_pkg;

    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin select: first requester after the last winner.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        int  j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between NUM_REQ requesters.
// Optional per-requester grant counters: define ALU_ARBITER_PERF_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
    input  logic [NUM_REQ*CTRL_W-1:0]    req_ctrl,
    output logic [DATA_WIDTH-1:0]        alu_op1,
    output logic [DATA_WIDTH-1:0]        alu_op2,
    output logic [CTRL_W-1:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0]        alu_out,
    input  logic                         alu_eq,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic [DATA_WIDTH-1:0]        resp_data,
    output logic                         resp_eq,
    output logic                         busy
`ifdef ALU_ARBITER_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]        grant_cnt
`endif
);

    state_t              state;
    state_t              state_n;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                hs;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid),
        .last  (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign hs   = (state == IDLE) && (|req_valid);
    assign busy = (state != IDLE);

    always_comb begin
        state_n    = state;
        req_ready  = '0;
        resp_valid = '0;
        unique case (state)
            IDLE: begin
                req_ready = pick_grant;
                if (|req_valid)
                    state_n = EXEC;
            end
            EXEC: state_n = RESP;
            RESP: begin
                resp_valid = NUM_REQ'(1) << id;
                if (resp_ready[id])
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // alu_* double as the operand latches, so they hold outside EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            id        <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_ctrl  <= '0;
            resp_data <= '0;
            resp_eq   <= 1'b0;
        end else begin
            state <= state_n;
            if (hs) begin
                rr_ptr   <= pick_idx;
                id       <= pick_idx;
                alu_op1  <= req_op1[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                alu_op2  <= req_op2[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                alu_ctrl <= req_ctrl[pick_idx*CTRL_W +: CTRL_W];
            end
            if (state == EXEC) begin
                resp_data <= alu_out;
                resp_eq   <= alu_eq;
            end
        end
    end

`ifdef ALU_ARBITER_PERF_EN
    logic [NUM_REQ-1:0][15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs && pick_grant[i] && cnt[i] != 16'hFFFF)
                    cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int DW = 32;
    localparam int NR = 2;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_op1;
    logic [NR*DW-1:0] req_op2;
    logic [NR*3-1:0] req_ctrl;
    logic [DW-1:0]   alu_op1;
    logic [DW-1:0]   alu_op2;
    logic [2:0]      alu_ctrl;
    logic [DW-1:0]   alu_out;
    logic            alu_eq;
    logic [NR-1:0]   resp_valid;
    logic [NR-1:0]   resp_ready;
    logic [DW-1:0]   resp_data;
    logic            resp_eq;
    logic            busy;
`ifdef ALU_ARBITER_PERF_EN
    logic [NR*16-1:0] grant_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_ctrl   (req_ctrl),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_eq     (alu_eq),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_eq    (resp_eq),
        .busy       (busy)
`ifdef ALU_ARBITER_PERF_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    // Stand-in for the shared ALU: add, otherwise subtract
    assign alu_out = (alu_ctrl == ALU_ADD) ? alu_op1 + alu_op2
                                           : alu_op1 - alu_op2;
    assign alu_eq  = (alu_op1 == alu_op2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // One full transaction from requester r with resp_ready held high
    task automatic run_op(input int r, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, output logic [DW-1:0] res);
        req_op1[r*DW +: DW] = a;
        req_op2[r*DW +: DW] = b;
        req_ctrl[r*3 +: 3]  = ALU_ADD;
        req_valid           = NR'(1) << r;
        resp_ready          = '1;
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        res = resp_data;
        resp_ready = '0;
    endtask

    logic [DW-1:0] res;
    logic [NR-1:0] exp_g;

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op1    = '0;
        req_op2    = '0;
        req_ctrl   = '0;
        resp_ready = '0;
        cyc();
        check("rst_ready", req_ready, 0);
        check("rst_rvalid", resp_valid, 0);
        check("rst_aluop1", alu_op1, 0);
        check("rst_rdata", resp_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        cyc();

        // single request 5 + 7
        req_op1[31:0] = 32'd5;
        req_op2[31:0] = 32'd7;
        req_valid = 2'b01;
        #1 check("single_ready", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        check("exec_op1", alu_op1, 5);
        check("exec_op2", alu_op2, 7);
        check("exec_busy", busy, 1);
        check("exec_ready", req_ready, 0);
        check("exec_rvalid", resp_valid, 0);
        cyc();
        check("resp_valid", resp_valid, 2'b01);
        check("resp_data", resp_data, 12);
        check("resp_eq0", resp_eq, 0);
        resp_ready = 2'b01;
        cyc();
        resp_ready = '0;
        check("back_idle", busy, 0);
        check("idle_rvalid", resp_valid, 0);

        // equality with wraparound
        run_op(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, res);
        check("eq_data", res, 32'hBD5B_7DDE);
        check("eq_flag", resp_eq, 1);
        cyc();
        check("alu_hold", alu_op1, 32'hDEAD_BEEF);

        // contention from reset: 0,1,0,1
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req_op1 = {32'd200, 32'd100};
        req_op2 = {32'd2, 32'd1};
        req_ctrl = '0;
        req_valid = 2'b11;
        resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1 check("cont_grant", req_ready, exp_g);
            cyc();
            check("cont_exec_rdy", req_ready, 0);
            cyc();
            check("cont_rvalid", resp_valid, exp_g);
            check("cont_data", resp_data, (k % 2 == 0) ? 101 : 202);
            cyc();
        end
        req_valid = '0;
        resp_ready = '0;
        cyc();

        // backpressure on requester 1, wrong-bit resp_ready ignored
        req_op1[63:32] = 32'd10;
        req_op2[63:32] = 32'd20;
        req_valid = 2'b10;
        #1 check("bp_grant", req_ready, 2'b10);
        cyc();
        req_valid = 2'b11;
        resp_ready = 2'b01;
        cyc();
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", resp_valid, 2'b10);
            check("bp_data", resp_data, 30);
            check("bp_ready", req_ready, 0);
            cyc();
        end
        resp_ready = 2'b10;
        cyc();
        resp_ready = '0;
        check("bp_idle", busy, 0);
        #1 check("bp_next_grant", req_ready, 2'b01);
        req_valid = '0;
        cyc();
        check("withdraw", busy, 0);

        // reset during EXEC
        req_op1[31:0] = 32'd1;
        req_op2[31:0] = 32'd1;
        req_valid = 2'b01;
        cyc();
        req_valid = '0;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_op1", alu_op1, 0);
        check("mid_rst_rvalid", resp_valid, 0);
        check("mid_rst_data", resp_data, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("mid_rst_norsp", resp_valid, 0);
        run_op(0, 32'd3, 32'd4, res);
        check("post_rst_data", res, 7);

`ifdef ALU_ARBITER_PERF_EN
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(1, 32'd1, 32'd1, res);
            cyc();
        end
        check("perf_cnt3", grant_cnt[31:16], 3);
        force dut.cnt[1] = 16'hFFFF;
        cyc();
        release dut.cnt[1];
        run_op(1, 32'd1, 32'd1, res);
        check("perf_sat", grant_cnt[31:16], 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
